// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller with per-source edge/level
// capture, lowest-index priority and a claim / complete / cooldown handshake.
module irq_controller #(
    parameter int unsigned NUM_SRC   = 8,
    parameter int unsigned VEC_W     = 4,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0020
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data,
    output logic               selected,
    output logic [VEC_W-1:0]   interrupt_vector,
    input  logic               interrupt_done
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COOLDOWN
    } state_t;

    localparam logic [3:0] OFF_PENDING = 4'h0;
    localparam logic [3:0] OFF_ENABLE  = 4'h4;
    localparam logic [3:0] OFF_MODE    = 4'h8;
    localparam logic [3:0] OFF_CLAIM   = 4'hC;

    logic [63:0]        offset;
    logic               sel_pending;
    logic               sel_enable;
    logic               sel_mode;
    logic               sel_claim;
    logic [NUM_SRC-1:0] wdata;
    logic               unused_wdata;

    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] done_clr;
    logic [VEC_W-1:0]   cand_vec;
    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vector_q, vector_d;

    assign wdata            = bus_write_data[NUM_SRC-1:0];
    assign unused_wdata     = ^bus_write_data[63:NUM_SRC];
    assign interrupt_vector = vector_q;

    // Window decode: the offset from the base must fall inside 16 bytes.
    always_comb begin
        offset      = bus_address - BASE_ADDR;
        selected    = (offset[63:4] == '0);
        sel_pending = selected && (offset[3:0] == OFF_PENDING);
        sel_enable  = selected && (offset[3:0] == OFF_ENABLE);
        sel_mode    = selected && (offset[3:0] == OFF_MODE);
        sel_claim   = selected && (offset[3:0] == OFF_CLAIM);
    end

    // Source history and a registered rising-edge strobe per line.
    always_comb begin
        src_d  = src_in;
        edge_d = src_in & ~src_q;
    end

    // Lowest enabled pending index wins; encoded directly as index+1.
    always_comb begin
        cand     = pending_q & enable_q;
        cand_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && (cand_vec == '0)) begin
                cand_vec = VEC_W'(i + 1);
            end
        end
    end

    // Claim FSM next state; completion frees the claimed source's bit.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        done_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (cand_vec != '0) begin
                    vector_d = cand_vec;
                    state_d  = ACTIVE;
                end else begin
                    vector_d = '0;
                end
            end
            ACTIVE: begin
                if (interrupt_done) begin
                    state_d  = COOLDOWN;
                    vector_d = '0;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        done_clr[i] = (vector_q == VEC_W'(i + 1));
                    end
                end
            end
            COOLDOWN: begin
                state_d  = IDLE;
                vector_d = '0;
            end
            default: begin
                state_d  = IDLE;
                vector_d = '0;
            end
        endcase
    end

    // Register file next state; a fresh edge overrides any clear.
    always_comb begin
        clr      = (bus_write_enable && sel_pending) ? wdata : '0;
        clr      = clr | done_clr;
        enable_d = (bus_write_enable && sel_enable) ? wdata : enable_q;
        mode_d   = (bus_write_enable && sel_mode) ? wdata : mode_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i]) begin
                pending_d[i] = (pending_q[i] & ~clr[i]) | edge_q[i];
            end else begin
                pending_d[i] = src_in[i];
            end
        end
    end

    // Read mux: zero-extended register or zero when not addressed.
    always_comb begin
        bus_read_data = '0;
        if (selected && bus_read_enable) begin
            unique case (1'b1)
                sel_pending: bus_read_data = 64'(pending_q);
                sel_enable:  bus_read_data = 64'(enable_q);
                sel_mode:    bus_read_data = 64'(mode_q);
                sel_claim:   bus_read_data = 64'(vector_q);
                default:     bus_read_data = '0;
            endcase
        end
    end

    // Source capture and software-visible registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
        end else begin
            src_q     <= src_d;
            edge_q    <= edge_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
        end
    end

    // Claim FSM state and registered vector output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            vector_q <= vector_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and randomized stimulus against a cycle-stamped
// behavioural model; a separate monitor scores vector changes and bus reads.
module tb_irq_controller;

    localparam int NS = 8;
    localparam int VW = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0020;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] src_in = '0;
    logic [63:0]   bus_address = '0;
    logic [63:0]   bus_write_data = '0;
    logic          bus_write_enable = 1'b0;
    logic          bus_read_enable = 1'b0;
    logic [63:0]   bus_read_data;
    logic          selected;
    logic [VW-1:0] interrupt_vector;
    logic          interrupt_done = 1'b0;

    irq_controller #(
        .NUM_SRC  (NS),
        .VEC_W    (VW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .src_in          (src_in),
        .bus_address     (bus_address),
        .bus_write_data  (bus_write_data),
        .bus_write_enable(bus_write_enable),
        .bus_read_enable (bus_read_enable),
        .bus_read_data   (bus_read_data),
        .selected        (selected),
        .interrupt_vector(interrupt_vector),
        .interrupt_done  (interrupt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vec;
        int cyc;
    } vec_ev_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic        sel;
    } rd_ev_t;

    vec_ev_t ev_q[$];
    rd_ev_t  rd_q[$];
    int      cyc = 0;
    bit      stim_done = 1'b0;
    int      checks = 0;
    int      errors = 0;

    // Reference model: pending/enable/mode as bit arrays, the current claim as
    // an integer vector, and cycle stamps for edge arrival and FSM readiness.
    bit m_pend[NS];
    bit m_en[NS];
    bit m_mode[NS];
    bit m_prev[NS];
    int m_set_at[NS];
    int m_vec = 0;
    int m_idle_from = 0;

    function automatic int reg_off(logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE;
        if (off < 64'd16) return int'(off[3:0]);
        return -1;
    endfunction

    function automatic logic [63:0] model_reg(int off);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            if (off == 0) r[i] = m_pend[i];
            if (off == 4) r[i] = m_en[i];
            if (off == 8) r[i] = m_mode[i];
        end
        if (off == 12) r = 64'(m_vec);
        return r;
    endfunction

    function automatic void push_ev(int v, int c);
        vec_ev_t e;
        e.vec = v;
        e.cyc = c;
        ev_q.push_back(e);
    endfunction

    function automatic void model_reset();
        if (m_vec != 0) push_ev(0, cyc);
        m_vec = 0;
        m_idle_from = 0;
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 1'b0;
            m_en[i] = 1'b0;
            m_mode[i] = 1'b0;
            m_prev[i] = 1'b0;
            m_set_at[i] = -10;
        end
    endfunction

    // One clock of the model, using the inputs the DUT sampled on this edge.
    function automatic void model_step();
        int nv = m_vec;
        int clr = -1;
        int off = reg_off(bus_address);
        bit wr = bus_write_enable && (off >= 0);
        bit np;
        if (m_vec != 0) begin
            if (interrupt_done) begin
                nv = 0;
                if (m_mode[m_vec-1]) clr = m_vec - 1;
                m_idle_from = cyc + 2;
            end
        end else if (cyc >= m_idle_from) begin
            for (int i = NS - 1; i >= 0; i--) begin
                if (m_pend[i] && m_en[i]) nv = i + 1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (m_mode[i]) begin
                np = m_pend[i];
                if ((wr && off == 0 && bus_write_data[i]) || clr == i) np = 1'b0;
                if (m_set_at[i] == cyc) np = 1'b1;
            end else begin
                np = src_in[i];
            end
            if (src_in[i] && !m_prev[i]) m_set_at[i] = cyc + 1;
            m_prev[i] = src_in[i];
            m_pend[i] = np;
            if (wr && off == 4) m_en[i] = bus_write_data[i];
            if (wr && off == 8) m_mode[i] = bus_write_data[i];
        end
        if (nv != m_vec) push_ev(nv, cyc + 1);
        m_vec = nv;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        cyc++;
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic wait_vec(int v);
        for (int k = 0; k < 20 && m_vec != v; k++) tick();
    endtask

    task automatic pulse_done();
        interrupt_done = 1'b1;
        tick();
        interrupt_done = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data);
        bus_address = addr;
        bus_write_data = data;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic read_push(input logic [63:0] addr, input logic [63:0] data,
                             input logic sel);
        rd_ev_t e;
        e.addr = addr;
        e.data = data;
        e.sel = sel;
        rd_q.push_back(e);
        bus_address = addr;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr);
        int off;
        off = reg_off(addr);
        if (off >= 0) read_push(addr, model_reg(off), 1'b1);
        else read_push(addr, 64'd0, 1'b0);
    endtask

    logic [63:0] offs[7] = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd2, 64'd16,
                             64'hFFFF_FFFF_FFFF_FFFC};

    // Stimulus: directed scenarios first, then a randomized soak.
    initial begin : driver
        logic [63:0] a_pend;
        logic [63:0] a_en;
        logic [63:0] a_mode;
        logic [63:0] a_claim;
        logic [63:0] a;
        int r;
        a_pend  = BASE;
        a_en    = BASE + 64'd4;
        a_mode  = BASE + 64'd8;
        a_claim = BASE + 64'd12;
        model_reset();
        ticks(3);
        reset = 1'b0;
        tick();
        read_push(a_pend, 64'd0, 1'b1);
        read_push(a_en, 64'd0, 1'b1);
        read_push(a_mode, 64'd0, 1'b1);
        read_push(a_claim, 64'd0, 1'b1);

        do_write(a_en, 64'h01);
        do_write(a_mode, 64'h01);
        src_in = 8'h01;
        tick();
        src_in = '0;
        wait_vec(1);
        ticks(2);
        read_push(a_claim, 64'd1, 1'b1);
        pulse_done();
        ticks(2);
        read_push(a_pend, 64'd0, 1'b1);

        do_write(a_en, 64'hFF);
        do_write(a_mode, 64'hFF);
        src_in = 8'h24;
        tick();
        src_in = '0;
        wait_vec(3);
        tick();
        pulse_done();
        wait_vec(6);
        tick();
        pulse_done();
        ticks(3);

        do_write(a_mode, 64'h00);
        do_write(a_en, 64'h02);
        src_in = 8'h02;
        wait_vec(2);
        tick();
        pulse_done();
        wait_vec(2);
        tick();
        src_in = '0;
        ticks(2);
        pulse_done();
        ticks(5);
        read_push(a_claim, 64'd0, 1'b1);

        do_write(a_mode, 64'h08);
        do_write(a_en, 64'h08);
        src_in = 8'h08;
        tick();
        src_in = '0;
        wait_vec(4);
        tick();
        do_write(a_en, 64'h00);
        ticks(4);
        read_push(a_claim, 64'd4, 1'b1);
        pulse_done();
        ticks(3);
        read_push(a_claim, 64'd0, 1'b1);

        src_in = 8'h08;
        tick();
        src_in = '0;
        ticks(2);
        read_push(a_pend, 64'h08, 1'b1);
        src_in = 8'h08;
        tick();
        src_in = '0;
        do_write(a_pend, 64'h08);
        read_push(a_pend, 64'h08, 1'b1);
        do_write(a_pend, 64'h08);
        read_push(a_pend, 64'h00, 1'b1);
        read_push(BASE + 64'd16, 64'd0, 1'b0);
        read_push(BASE - 64'd4, 64'd0, 1'b0);

        do_write(a_mode, 64'h01);
        do_write(a_en, 64'h01);
        src_in = 8'h01;
        tick();
        src_in = '0;
        wait_vec(1);
        tick();
        reset = 1'b1;
        model_reset();
        ticks(2);
        reset = 1'b0;
        tick();
        read_push(a_pend, 64'd0, 1'b1);
        read_push(a_en, 64'd0, 1'b1);
        read_push(a_mode, 64'd0, 1'b1);
        read_push(a_claim, 64'd0, 1'b1);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0)
                src_in = src_in ^ NS'(1 << $urandom_range(0, NS - 1));
            interrupt_done = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 9);
            a = BASE + offs[$urandom_range(0, 6)];
            if (r == 0) do_write(a, {$urandom, $urandom});
            else if (r <= 2) do_read(a);
            else tick();
        end
        interrupt_done = 1'b0;
        ticks(6);
        stim_done = 1'b1;
    end

    // Monitor: scores every vector change and every read against the queues.
    initial begin : monitor
        logic [VW-1:0] last;
        int ei;
        int ri;
        last = '0;
        ei = 0;
        ri = 0;
        forever begin
            @(negedge clk);
            if (interrupt_vector != last) begin
                checks++;
                if (ei >= ev_q.size()) begin
                    errors++;
                    $display("FAIL vec_event: got %0d at cycle %0d, required no change",
                             interrupt_vector, cyc);
                end else begin
                    if (int'(interrupt_vector) != ev_q[ei].vec || cyc != ev_q[ei].cyc) begin
                        errors++;
                        $display("FAIL vec_event: got %0d at cycle %0d, required %0d at cycle %0d",
                                 interrupt_vector, cyc, ev_q[ei].vec, ev_q[ei].cyc);
                    end
                    ei++;
                end
                last = interrupt_vector;
            end
            if (bus_read_enable) begin
                checks++;
                if (ri >= rd_q.size()) begin
                    errors++;
                    $display("FAIL read: unexpected read at cycle %0d", cyc);
                end else begin
                    if (bus_read_data !== rd_q[ri].data || selected !== rd_q[ri].sel) begin
                        errors++;
                        $display("FAIL read @%h: got data %h sel %0b, required data %h sel %0b",
                                 rd_q[ri].addr, bus_read_data, selected,
                                 rd_q[ri].data, rd_q[ri].sel);
                    end
                    ri++;
                end
            end
            if (stim_done || cyc > 40000) begin
                checks++;
                if (!stim_done) begin
                    errors++;
                    $display("FAIL timeout: got cycle %0d, required stimulus end", cyc);
                end
                checks++;
                if (ei != ev_q.size()) begin
                    errors++;
                    $display("FAIL vec_drain: got %0d vector events, required %0d",
                             ei, ev_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal 1..2**VEC_W-1).
REQ-002 SHALL have parameter VEC_W, default 4, width of interrupt_vector.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0020, register block base.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; clock and reset ports are named clk and reset.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 src_in  input  NUM_SRC  interrupt request lines, synchronous to clk.
REQ-008 bus_address  input  64  byte address from CPU bus.
REQ-009 bus_write_data  input  64  write data; bits [NUM_SRC-1:0] used.
REQ-010 bus_write_enable  input  1  single-cycle write strobe.
REQ-011 bus_read_enable  input  1  read qualifier.
REQ-012 bus_read_data  output  64  read data, combinational from address.
REQ-013 selected  output  1  high when bus_address falls in BASE_ADDR..BASE_ADDR+0xF.
REQ-014 interrupt_vector  output  VEC_W  0 = none; k = source k-1 claimed.
REQ-015 interrupt_done  input  1  CPU completion acknowledge.

Function
REQ-016 Registers (offset, access): 0x0 PENDING (RO; write-1-to-clear), 0x4 ENABLE (RW), 0x8 MODE (RW; bit=1 rising-edge, 0 level), 0xC CLAIM (RO; current vector, zero-extended).
REQ-017 Writes SHALL take effect on the clk edge where bus_write_enable and selected are high; writes to CLAIM ignored.
REQ-018 bus_read_data SHALL be the addressed register zero-extended to 64 bits when selected and bus_read_enable are high, else 0; unused offsets read 0.
REQ-019 Edge source: pending bit SHALL set on the cycle after src_in 0->1 (one register stage for edge detect) and hold until cleared.
REQ-020 Level source: pending bit SHALL equal registered src_in.
REQ-021 Edge set and W1C clear of the same bit in the same cycle: set SHALL win.
REQ-022 Candidate = PENDING & ENABLE; lowest index SHALL have highest priority.
REQ-023 FSM states IDLE, ACTIVE, COOLDOWN.
REQ-024 IDLE: if candidate nonzero, latch index i, drive interrupt_vector = i+1 next cycle, go ACTIVE; else interrupt_vector = 0.
REQ-025 ACTIVE: interrupt_vector held constant regardless of ENABLE/PENDING changes; on interrupt_done=1 go COOLDOWN and clear pending[i] if source i is edge mode.
REQ-026 COOLDOWN: interrupt_vector = 0 for exactly one cycle, then IDLE; interrupt_done ignored.
REQ-027 interrupt_done high in IDLE or COOLDOWN SHALL have no effect.
REQ-028 Edge on claimed source i during ACTIVE SHALL re-pend after the clear (new edge wins, per REQ-021).
REQ-029 Level source still high after completion SHALL be re-claimed at earliest in the IDLE cycle following COOLDOWN.
REQ-030 Minimum interrupt latency: src_in edge at cycle n -> interrupt_vector nonzero at cycle n+3.

Reset
REQ-031 On reset: PENDING=0, ENABLE=0, MODE=0, edge-detect history=0, FSM=IDLE, interrupt_vector=0, CLAIM=0.
REQ-032 Reset asserted mid-ACTIVE SHALL drop interrupt_vector to 0 asynchronously; no pending state survives.
REQ-033 selected and bus_read_data are combinational and not reset-dependent except through register contents.

Verification
REQ-034 ENABLE=0x01, MODE=0x01, pulse src_in[0] at cycle n -> interrupt_vector=1 at n+3; interrupt_done -> vector 0 one cycle, PENDING[0]=0.
REQ-035 ENABLE=0xFF, MODE=0xFF, src_in[5] and src_in[2] rise same cycle -> vector=3 first; after done+cooldown vector=6.
REQ-036 MODE=0 (level), src_in[1] held high, ENABLE=0x02 -> vector=2, done, one zero cycle, vector=2 again; drop src_in[1] before done -> vector 0 stays after cooldown.
REQ-037 Write 0x00 to ENABLE while vector=4 active -> vector stays 4 until interrupt_done; then 0.
REQ-038 W1C 0x08 to PENDING same cycle as new edge on src_in[3] -> PENDING[3] reads 1; read of offset 0x10 with selected low -> bus_read_data 0.
REQ-039 Assert reset while vector=1 -> vector 0 immediately; after release all registers read 0.
